// File: rtl/sp_ram_arb2.sv
// Two-port valid/ready arbiter in front of one single-port synchronous RAM, with a zero-fill engine.
// Define ARB_FIXED_PRIO_EN for fixed priority (A wins); the default is round-robin.
module sp_ram_arb2 #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  wclk,
    input  logic                  rst,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    input  logic                  clr_start,
    output logic                  clr_busy,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    typedef enum logic {ARB, CLEAR} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   clr_cnt_reg, clr_cnt_next;
    logic                    grant_a, grant_b;
    logic                    arb_open, accept_a, accept_b;
    logic [ADDR_WIDTH-1:0]   ram_addr_reg;
    logic [DATA_WIDTH-1:0]   ram_din_reg;
    logic                    ram_we_reg;
    logic                    tag1_vld_reg, tag1_port_reg;
    logic                    tag2_vld_reg, tag2_port_reg;

    // A clear request in the same cycle as a client request takes precedence.
    assign arb_open = (state_reg == ARB) && !clr_start;
    assign accept_a = arb_open && grant_a;
    assign accept_b = arb_open && grant_b;
    assign a_ready  = accept_a;
    assign b_ready  = accept_b;
    assign clr_busy = (state_reg == CLEAR);

`ifdef ARB_FIXED_PRIO_EN
    assign grant_a = a_valid;
    assign grant_b = b_valid && !a_valid;
`else
    logic rr_reg;  // 1: B wins the next contention

    assign grant_a = a_valid && !(b_valid && rr_reg);
    assign grant_b = b_valid && !(a_valid && !rr_reg);

    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            rr_reg <= 1'b0;
        end else if (accept_a) begin
            rr_reg <= 1'b1;
        end else if (accept_b) begin
            rr_reg <= 1'b0;
        end
    end
`endif

    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        case (state_reg)
            ARB: begin
                if (clr_start) begin
                    state_next   = CLEAR;
                    clr_cnt_next = '0;
                end
            end
            CLEAR: begin
                if (clr_cnt_reg == LAST_ADDR) begin
                    state_next   = ARB;
                    clr_cnt_next = '0;
                end else begin
                    clr_cnt_next = clr_cnt_reg + ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_next   = ARB;
                clr_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            state_reg   <= ARB;
            clr_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    // RAM pins: address and data hold across idle cycles, only the enable drops.
    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            ram_addr_reg <= '0;
            ram_din_reg  <= '0;
            ram_we_reg   <= 1'b0;
        end else if (accept_a) begin
            ram_addr_reg <= a_addr;
            ram_din_reg  <= a_wdata;
            ram_we_reg   <= a_we;
        end else if (accept_b) begin
            ram_addr_reg <= b_addr;
            ram_din_reg  <= b_wdata;
            ram_we_reg   <= b_we;
        end else if (state_reg == CLEAR) begin
            ram_addr_reg <= clr_cnt_reg;
            ram_din_reg  <= '0;
            ram_we_reg   <= 1'b1;
        end else begin
            ram_we_reg   <= 1'b0;
        end
    end

    assign ram_addr = ram_addr_reg;
    assign ram_din  = ram_din_reg;
    assign ram_we   = ram_we_reg;

    // Tag stage 1 tracks the pin cycle, stage 2 the RAM output cycle.
    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            tag1_vld_reg  <= 1'b0;
            tag1_port_reg <= 1'b0;
            tag2_vld_reg  <= 1'b0;
            tag2_port_reg <= 1'b0;
        end else begin
            tag1_vld_reg  <= (accept_a && !a_we) || (accept_b && !b_we);
            tag1_port_reg <= accept_b;
            tag2_vld_reg  <= tag1_vld_reg;
            tag2_port_reg <= tag1_port_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            logic                  rvalid_reg;
            logic [DATA_WIDTH-1:0] rdata_reg;
            logic                  hit;

            assign hit = tag2_vld_reg && (tag2_port_reg == 1'(gi));

            always_ff @(posedge wclk or posedge rst) begin
                if (rst) begin
                    rvalid_reg <= 1'b0;
                    rdata_reg  <= '0;
                end else begin
                    rvalid_reg <= hit;
                    if (hit) begin
                        rdata_reg <= ram_dout;
                    end
                end
            end
        end
    endgenerate

    assign a_rvalid = g_resp[0].rvalid_reg;
    assign a_rdata  = g_resp[0].rdata_reg;
    assign b_rvalid = g_resp[1].rvalid_reg;
    assign b_rdata  = g_resp[1].rdata_reg;

endmodule

// File: tb/tb_sp_ram_arb2.sv
// Randomized bench for sp_ram_arb2 with a RAM model and a transaction-level reference model.
// Build with ARB_FIXED_PRIO_EN defined to check the fixed-priority variant.
module tb_sp_ram_arb2;

    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;

    logic          wclk = 1'b0;
    logic          rst;
    logic          a_valid, a_ready, a_we, a_rvalid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_valid, b_ready, b_we, b_rvalid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic          clr_start, clr_busy;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;
    logic          ram_we;

    sp_ram_arb2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH)) dut (
        .wclk(wclk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .clr_start(clr_start), .clr_busy(clr_busy),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
    );

    always #5 wclk = ~wclk;

    // Single-port synchronous RAM, read-first.
    logic          ram_init;
    logic [DW-1:0] mem [DEPTH];
    always @(posedge wclk) begin
        if (ram_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (ram_we) mem[ram_addr] <= ram_din;
            ram_dout <= mem[ram_addr];
        end
    end

    // Reference model state
    typedef struct {
        int            cyc;
        bit            port;
        logic [DW-1:0] data;
    } resp_t;

    resp_t         rq[$];
    logic [DW-1:0] ref_mem [DEPTH];
    int            cyc;
    int            busy_left;
    bit            last_a;
    int            n_checks = 0;
    int            n_pass   = 0;

    // pending client requests (held until accepted)
    bit            a_v, a_w, b_v, b_w;
    logic [AW-1:0] a_ad, b_ad;
    logic [DW-1:0] a_wd, b_wd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic set_a(input bit we, input int addr, input logic [DW-1:0] data);
        if (!a_v) begin
            a_v = 1'b1; a_w = we; a_ad = AW'(addr); a_wd = data;
        end
    endtask

    task automatic set_b(input bit we, input int addr, input logic [DW-1:0] data);
        if (!b_v) begin
            b_v = 1'b1; b_w = we; b_ad = AW'(addr); b_wd = data;
        end
    endtask

    // One clock cycle: drive, check grants, advance model, check responses.
    task automatic step(input bit clr);
        bit ga, gb;
        bit exp_av, exp_bv;
        logic [DW-1:0] exp_ad, exp_bd;
        resp_t r;
        clr_start = clr;
        a_valid = a_v; a_we = a_w; a_addr = a_ad; a_wdata = a_wd;
        b_valid = b_v; b_we = b_w; b_addr = b_ad; b_wdata = b_wd;
        #1;
        ga = 1'b0; gb = 1'b0;
        if (busy_left == 0 && !clr) begin
            if (a_v && b_v) begin
`ifdef ARB_FIXED_PRIO_EN
                ga = 1'b1;
`else
                ga = !last_a;
`endif
                gb = !ga;
            end else begin
                ga = a_v;
                gb = b_v;
            end
        end
        check("a_ready", a_ready, ga);
        check("b_ready", b_ready, gb);
        if (ga) begin
            if (a_w) ref_mem[a_ad] = a_wd;
            else begin r.cyc = cyc + 3; r.port = 1'b0; r.data = ref_mem[a_ad]; rq.push_back(r); end
            last_a = 1'b1;
            $display("cyc %0d: grant A %s addr %0d data 0x%04h", cyc, a_w ? "WR" : "RD", a_ad, a_w ? a_wd : ref_mem[a_ad]);
            a_v = 1'b0;
        end
        if (gb) begin
            if (b_w) ref_mem[b_ad] = b_wd;
            else begin r.cyc = cyc + 3; r.port = 1'b1; r.data = ref_mem[b_ad]; rq.push_back(r); end
            last_a = 1'b0;
            $display("cyc %0d: grant B %s addr %0d data 0x%04h", cyc, b_w ? "WR" : "RD", b_ad, b_w ? b_wd : ref_mem[b_ad]);
            b_v = 1'b0;
        end
        if (busy_left > 0) busy_left--;
        else if (clr) begin
            busy_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
            $display("cyc %0d: clear started", cyc);
        end
        @(posedge wclk);
        #1;
        cyc++;
        clr_start = 1'b0;
        check("clr_busy", clr_busy, busy_left > 0);
        exp_av = 1'b0; exp_bv = 1'b0; exp_ad = '0; exp_bd = '0;
        if (rq.size() > 0 && rq[0].cyc == cyc) begin
            r = rq.pop_front();
            if (r.port) begin exp_bv = 1'b1; exp_bd = r.data; end
            else begin exp_av = 1'b1; exp_ad = r.data; end
        end
        check("a_rvalid", a_rvalid, exp_av);
        check("b_rvalid", b_rvalid, exp_bv);
        if (exp_av) check("a_rdata", a_rdata, exp_ad);
        if (exp_bv) check("b_rdata", b_rdata, exp_bd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a_ready"},  a_ready,  0);
        check({tag, "_b_ready"},  b_ready,  0);
        check({tag, "_a_rvalid"}, a_rvalid, 0);
        check({tag, "_b_rvalid"}, b_rvalid, 0);
        check({tag, "_a_rdata"},  a_rdata,  0);
        check({tag, "_b_rdata"},  b_rdata,  0);
        check({tag, "_clr_busy"}, clr_busy, 0);
        check({tag, "_ram_addr"}, ram_addr, 0);
        check({tag, "_ram_din"},  ram_din,  0);
        check({tag, "_ram_we"},   ram_we,   0);
    endtask

    task automatic model_reset();
        rq.delete();
        busy_left = 0;
        last_a = 1'b0;
        a_v = 1'b0; b_v = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; clr_start = 1'b0;
    endtask

    initial begin
        a_w = 1'b0; b_w = 1'b0; a_ad = '0; b_ad = '0; a_wd = '0; b_wd = '0;
        a_we = 1'b0; b_we = 1'b0; a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
        model_reset();
        cyc = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        rst = 1'b1; ram_init = 1'b1;
        repeat (3) @(posedge wclk);
        #1;
        check_all_zero("reset");
        @(negedge wclk);
        rst = 1'b0; ram_init = 1'b0;
        @(posedge wclk);
        #1;

        // write then read the same word from A
        set_a(1'b1, 3, 16'h1234); step(1'b0);
        set_a(1'b0, 3, 16'h0000); step(1'b0);
        idle(3);

        // contention: both ports reading every cycle
        for (int i = 0; i < 6; i++) begin
            set_a(1'b0, i, 16'h0);
            set_b(1'b0, 7 - i, 16'h0);
            step(1'b0);
        end
        idle(6);

        // write on A followed by read on B of the same address
        set_a(1'b1, 5, 16'hBEEF); step(1'b0);
        set_b(1'b0, 5, 16'h0000); step(1'b0);
        idle(3);

        // fill with ones, clear (A request pending alongside), second pulse mid-clear ignored
        for (int i = 0; i < DEPTH; i++) begin
            set_a(1'b1, i, 16'hFFFF); step(1'b0);
        end
        set_a(1'b0, 2, 16'h0);
        step(1'b1);
        for (int i = 0; i < DEPTH + 2; i++) step(i == 3);
        for (int i = 0; i < DEPTH; i++) begin
            set_a(1'b0, i, 16'h0); step(1'b0);
        end
        idle(4);

        // equal contention for four cycles
        for (int i = 0; i < 4; i++) begin
            set_a(1'b1, i, 16'(16'hA000 + i));
            set_b(1'b1, i + 4, 16'(16'hB000 + i));
            step(1'b0);
        end
        idle(6);

        // randomized traffic with occasional clears
        for (int n = 0; n < 400; n++) begin
            if (!a_v && $urandom_range(0, 2) != 0)
                set_a(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)), 16'($urandom));
            if (!b_v && $urandom_range(0, 2) != 0)
                set_b(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)), 16'($urandom));
            step($urandom_range(0, 39) == 0);
        end
        a_v = 1'b0; b_v = 1'b0;
        idle(DEPTH + 4);

        // reset one cycle after a read is accepted: the read must vanish
        set_a(1'b1, 6, 16'h5A5A); step(1'b0);
        set_a(1'b0, 6, 16'h0); step(1'b0);
        step(1'b0);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        model_reset();
        repeat (2) @(posedge wclk);
        @(negedge wclk);
        rst = 1'b0;
        @(posedge wclk);
        #1;
        idle(5);
        set_b(1'b0, 6, 16'h0); step(1'b0);
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
